seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised sequential ALU for the RISC datapath. Replaces the purely combinational ALU: single-cycle logic/arithmetic/shift ops complete in one clock, and signed multiply and divide run as iterative multi-cycle ops behind a start/busy/done handshake. Sits between the operand registers and the Z register pair, with `result_hi`/`result_lo` feeding HI/LO.

## Interface
- `WIDTH`, 32, operand and result width; must be ≥4 and a power of two.
- `clock` in 1, sole clock, rising edge.
- `clear` in 1, synchronous active-high reset.
- `start` in 1, request; sampled only in IDLE.
- `opcode` in 5, operation select; sampled with `start`.
- `input_a` in WIDTH, operand A; sampled with `start`.
- `input_b` in WIDTH, operand B; sampled with `start`.
- `busy` out 1, high while a multi-cycle op is in progress.
- `done` out 1, one-cycle pulse when results are valid.
- `result_lo` out WIDTH, primary result, product low word, or quotient.
- `result_hi` out WIDTH, product high word or remainder; 0 for single-cycle ops.
- `div_by_zero` out 1, valid with `done`; set for DIV with B=0.
- `illegal_op` out 1, valid with `done`; set for an unassigned opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 DIV, 10 NEG, 11 NOT. Opcodes 12–31 are illegal.
- ADD, SUB, and NEG are modulo 2^WIDTH. No carry or overflow outputs.
- Shift and rotate amount: `input_b[$clog2(WIDTH)-1:0]`. Upper bits are ignored.
- MUL: signed × signed, 2·WIDTH-bit product, {hi, lo}.
- DIV: signed and truncating toward zero. Quotient goes to lo; remainder goes to hi, with the remainder's sign following the dividend.
- DIV by zero: lo = all ones, hi = input_a, `div_by_zero`=1.
- Illegal op: lo = hi = 0, `illegal_op`=1, single-cycle timing.
- FSM states:
  - IDLE: on `start` with a single-cycle or illegal op, stay in IDLE and register results plus `done`. On `start` with MUL or DIV, latch operand magnitudes and signs, then go to RUN.
  - RUN: one iteration per clock (shift-add or restoring subtract) for WIDTH clocks, then go to FIX.
  - FIX: apply sign correction, register results, pulse `done`, return to IDLE.
- `start` while `busy` is ignored; there is no queue.
- Results and flags hold their values until the next `done`. Flags are updated only at `done`.
- `clear` in any state:
  - next state is IDLE;
  - all outputs become 0 on the next cycle;
  - an in-flight op is abandoned with no `done`.
- `clear` together with `start`: `clear` wins.

## Timing
- `start` is sampled at edge N.
- Single-cycle ops: `done` and results are visible in cycle N+1. `busy` stays 0.
- MUL/DIV: `busy`=1 from cycle N+1 through cycle N+WIDTH+1. `done` is high in cycle N+WIDTH+2 with `busy`=0. Latency is WIDTH+2 clocks (34 at WIDTH=32).
- A new `start` is accepted in the same cycle that `done` is high.
- Reset values: `busy`, `done`, `result_lo`, `result_hi`, `div_by_zero`, and `illegal_op` are all 0. State is IDLE.

## Configuration
- `SEQ_ALU_DIV_EN` defined: divider datapath is present, and DIV behaves as specified.
- `SEQ_ALU_DIV_EN` undefined: opcode 9 is treated as illegal (single-cycle, results 0, `illegal_op`=1). `div_by_zero` is tied to 0. The restoring-subtract logic is not built.

## Structure
- `seq_alu_pkg` holds:
  - opcode localparams/enum (ALU_ADD … ALU_NOT);
  - the FSM state typedef;
  - an `is_multicycle(opcode)` function.
- Sub-module `seq_alu_muldiv` holds the shared shift register, iteration counter, and sign-fix logic for MUL/DIV. It is controlled by the top-level FSM.

## Test plan
- Single-cycle ops, WIDTH=32:
  - ADD a=2, b=3: next cycle lo=5, hi=0, `done`=1, `busy` never high.
  - SUB a=12, b=17: lo=0xFFFFFFFB.
- ROR a=0x00000001, b=0x21: shift amount 1, lo=0x80000000. Then SHR a=0x80000000, b=4: lo=0x08000000.
- MUL a=−6, b=7:
  - `busy` for 33 cycles, `done` in cycle N+34;
  - hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- DIV cases:
  - a=17, b=−5: lo=0xFFFFFFFD (−3), hi=2;
  - a=17, b=0: lo=0xFFFFFFFF, hi=17, `div_by_zero`=1;
  - without `SEQ_ALU_DIV_EN`: DIV gives `illegal_op`=1 with single-cycle `done`.
- Start MUL, pulse `start` with ADD at cycle N+5: ADD is ignored and the MUL result is correct. Start MUL again, assert `clear` at N+10: outputs go to 0, there is no `done`, and a following ADD 2+3 returns 5.
- Opcode 20 gives `illegal_op`=1 with lo=hi=0. The next legal op clears `illegal_op`.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and op classification for seq_alu.
// SEQ_ALU_DIV_EN selects whether DIV is a multi-cycle op or an illegal opcode.
package seq_alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SHR = 5'd4,
        ALU_SHL = 5'd5,
        ALU_ROR = 5'd6,
        ALU_ROL = 5'd7,
        ALU_MUL = 5'd8,
        ALU_DIV = 5'd9,
        ALU_NEG = 5'd10,
        ALU_NOT = 5'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [4:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIV);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative signed multiply / divide engine on unsigned magnitudes, with sign fix-up.
// The restoring divider is only built when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    // hi/lo form one 2*WIDTH shift register: multiplier/product for MUL,
    // remainder/quotient for DIV. mcand holds |b| in both cases.
    logic [WIDTH-1:0]   hi, lo, mcand;
    logic               sa, sb;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign mul_sum  = {1'b0, hi} + {1'b0, mcand};
    assign prod     = {hi, lo};
    assign prod_fix = (sa ^ sb) ? -prod : prod;
    assign last     = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_ALU_DIV_EN
    logic           is_div;
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;

    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ge    = (div_shift >= {1'b0, mcand});
`else
    logic unused_op_div;
    assign unused_op_div = op_div;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            cnt   <= '0;
`ifdef SEQ_ALU_DIV_EN
            is_div <= 1'b0;
`endif
        end else if (load) begin
            hi    <= '0;
            lo    <= a[WIDTH-1] ? -a : a;
            mcand <= b[WIDTH-1] ? -b : b;
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
            cnt   <= '0;
`ifdef SEQ_ALU_DIV_EN
            is_div <= op_div;
`endif
        end else if (step) begin
            cnt <= cnt + 1'b1;
`ifdef SEQ_ALU_DIV_EN
            if (is_div) begin
                hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], div_ge};
            end else
`endif
            begin
                hi <= lo[0] ? mul_sum[WIDTH:1] : {1'b0, hi[WIDTH-1:1]};
                lo <= {(lo[0] ? mul_sum[0] : hi[0]), lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        dbz    = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        if (is_div) begin
            res_lo = (sa ^ sb) ? -lo : lo;
            res_hi = sa ? -hi : hi;
            // Divisor 0: every step subtracts nothing, so hi already rebuilds a.
            if (mcand == '0) begin
                res_lo = '1;
                dbz    = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
// DIV is built only when SEQ_ALU_DIV_EN is defined; otherwise it is illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int SW = $clog2(WIDTH);

    state_e             state, state_next;
    logic               accept, multi, load, step, last;
    logic [WIDTH-1:0]   md_hi, md_lo;
    logic               md_dbz;
    logic [WIDTH-1:0]   sc_lo;
    logic               sc_ill;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] dbl, rot_r, rot_l;

    assign multi  = is_multicycle(opcode);
    assign accept = (state == ST_IDLE) && start;

    always_ff @(posedge clock) begin
        if (clear) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && multi) state_next = ST_RUN;
            ST_RUN:  if (last) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        load = accept && multi;
        step = (state == ST_RUN);
    end

    // Rotates read a window out of the operand concatenated with itself.
    assign shamt = input_b[SW-1:0];
    assign dbl   = {input_a, input_a};
    assign rot_r = dbl >> shamt;
    assign rot_l = dbl << shamt;

    always_comb begin
        sc_lo  = '0;
        sc_ill = 1'b0;
        case (opcode)
            ALU_ADD: sc_lo = input_a + input_b;
            ALU_SUB: sc_lo = input_a - input_b;
            ALU_AND: sc_lo = input_a & input_b;
            ALU_OR:  sc_lo = input_a | input_b;
            ALU_SHR: sc_lo = input_a >> shamt;
            ALU_SHL: sc_lo = input_a << shamt;
            ALU_ROR: sc_lo = rot_r[WIDTH-1:0];
            ALU_ROL: sc_lo = rot_l[2*WIDTH-1:WIDTH];
            ALU_NEG: sc_lo = '0 - input_a;
            ALU_NOT: sc_lo = ~input_a;
            default: sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !multi) begin
                result_lo   <= sc_lo;
                result_hi   <= '0;
                div_by_zero <= 1'b0;
                illegal_op  <= sc_ill;
                done        <= 1'b1;
            end else if (state == ST_FIX) begin
                result_lo   <= md_lo;
                result_hi   <= md_hi;
                div_by_zero <= md_dbz;
                illegal_op  <= 1'b0;
                done        <= 1'b1;
            end
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .clear  (clear),
        .load   (load),
        .step   (step),
        .op_div (opcode == ALU_DIV),
        .a      (input_a),
        .b      (input_b),
        .last   (last),
        .res_hi (md_hi),
        .res_lo (md_lo),
        .dbz    (md_dbz)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu at WIDTH=32 against a plain-arithmetic model.
// Honors SEQ_ALU_DIV_EN the same way as the design.
module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clock, clear, start;
    logic [4:0]   opcode;
    logic [W-1:0] input_a, input_b;
    logic         busy, done, div_by_zero, illegal_op;
    logic [W-1:0] result_lo, result_hi;

    int tests_run = 0;
    int tests_failed = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .input_a(input_a), .input_b(input_b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz, output logic il, output int lat, output int bcy);
        longint la, lb, p, q, r;
        int s;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        s  = int'(b[4:0]);
        lo = '0; hi = '0; dz = 1'b0; il = 1'b0; lat = 1; bcy = 0;
        case (op)
            5'd0:  lo = a + b;
            5'd1:  lo = a - b;
            5'd2:  lo = a & b;
            5'd3:  lo = a | b;
            5'd4:  lo = a >> s;
            5'd5:  lo = a << s;
            5'd6:  begin lo = a; repeat (s) lo = {lo[0], lo[W-1:1]}; end
            5'd7:  begin lo = a; repeat (s) lo = {lo[W-2:0], lo[W-1]}; end
            5'd8:  begin p = la * lb; {hi, lo} = p; lat = W + 2; bcy = W + 1; end
            5'd9:  begin
                if (!DIV_EN) il = 1'b1;
                else begin
                    lat = W + 2; bcy = W + 1;
                    if (lb == 0) begin lo = '1; hi = a; dz = 1'b1; end
                    else begin q = la / lb; r = la % lb; lo = q[W-1:0]; hi = r[W-1:0]; end
                end
            end
            5'd10: lo = -a;
            5'd11: lo = ~a;
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcy);
        @(negedge clock);
        start = 1'b1; opcode = op; input_a = a; input_b = b;
        @(negedge clock);
        start = 1'b0;
        lat = 1; bcy = 0;
        while (!done && lat < 100) begin
            if (busy) bcy++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; opcode = '0; input_a = '0; input_b = '0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({busy, done, result_lo, result_hi, div_by_zero, illegal_op} !== '0) begin
            tests_failed++;
            $display("FAIL reset: got busy=%b done=%b lo=%h hi=%h dz=%b il=%b, want all 0",
                     busy, done, result_lo, result_hi, div_by_zero, illegal_op);
        end
        clear = 1'b0;
    endtask

    task automatic test_single();
        logic [4:0] op; logic [W-1:0] a, b, elo, ehi; logic edz, eil; int lat, bcy, elat, ebcy, pick;
        for (int i = 0; i < 45; i++) begin
            case (i)
                0: begin op = 5'd0; a = 32'd2;          b = 32'd3;  end
                1: begin op = 5'd1; a = 32'd12;         b = 32'd17; end
                2: begin op = 5'd6; a = 32'h00000001;   b = 32'h21; end
                3: begin op = 5'd4; a = 32'h80000000;   b = 32'd4;  end
                4: begin op = 5'd7; a = 32'h80000001;   b = 32'd33; end
                default: begin
                    pick = int'($urandom_range(0, 9));
                    op = 5'((pick < 8) ? pick : pick + 2);
                    a = $urandom; b = $urandom;
                end
            endcase
            run_op(op, a, b, lat, bcy);
            model(op, a, b, elo, ehi, edz, eil, elat, ebcy);
            tests_run++;
            if ({done, busy, result_lo, result_hi, div_by_zero, illegal_op} !== {2'b10, elo, ehi, edz, eil}
                || lat != elat || bcy != ebcy) begin
                tests_failed++;
                $display("FAIL single op=%0d a=%h b=%h: got lo=%h hi=%h dz=%b il=%b lat=%0d busycy=%0d, want lo=%h hi=%h dz=%b il=%b lat=%0d busycy=%0d",
                         op, a, b, result_lo, result_hi, div_by_zero, illegal_op, lat, bcy, elo, ehi, edz, eil, elat, ebcy);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] a, b, elo, ehi; logic edz, eil; int lat, bcy, elat, ebcy;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin a = -32'sd6;        b = 32'd7;        end
                1: begin a = 32'h80000000;   b = 32'h80000000; end
                2: begin a = 32'hFFFFFFFF;   b = 32'hFFFFFFFF; end
                3: begin a = 32'h7FFFFFFF;   b = 32'h80000000; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(5'd8, a, b, lat, bcy);
            model(5'd8, a, b, elo, ehi, edz, eil, elat, ebcy);
            tests_run++;
            if ({done, busy, result_lo, result_hi, div_by_zero, illegal_op} !== {2'b10, elo, ehi, edz, eil}
                || lat != elat || bcy != ebcy) begin
                tests_failed++;
                $display("FAIL mul a=%h b=%h: got lo=%h hi=%h lat=%0d busycy=%0d, want lo=%h hi=%h lat=%0d busycy=%0d",
                         a, b, result_lo, result_hi, lat, bcy, elo, ehi, elat, ebcy);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] a, b, elo, ehi, tmp; logic edz, eil; int lat, bcy, elat, ebcy;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: begin a = 32'd17;         b = -32'sd5;      end
                1: begin a = 32'd17;         b = 32'd0;        end
                2: begin a = -32'sd17;       b = 32'd5;        end
                3: begin a = -32'sd17;       b = -32'sd5;      end
                4: begin a = 32'h80000000;   b = 32'hFFFFFFFF; end
                5: begin a = -32'sd7;        b = 32'd0;        end
                default: begin
                    a = $urandom;
                    tmp = $urandom;
                    b = ($urandom_range(0, 4) == 0) ? '0 : 32'($signed(tmp) >>> $urandom_range(0, 31));
                end
            endcase
            run_op(5'd9, a, b, lat, bcy);
            model(5'd9, a, b, elo, ehi, edz, eil, elat, ebcy);
            tests_run++;
            if ({done, busy, result_lo, result_hi, div_by_zero, illegal_op} !== {2'b10, elo, ehi, edz, eil}
                || lat != elat || bcy != ebcy) begin
                tests_failed++;
                $display("FAIL div a=%h b=%h: got lo=%h hi=%h dz=%b il=%b lat=%0d busycy=%0d, want lo=%h hi=%h dz=%b il=%b lat=%0d busycy=%0d",
                         a, b, result_lo, result_hi, div_by_zero, illegal_op, lat, bcy, elo, ehi, edz, eil, elat, ebcy);
            end
        end
    endtask

    task automatic test_illegal();
        logic [4:0] op; logic [W-1:0] a, b, elo, ehi; logic edz, eil; int lat, bcy, elat, ebcy;
        for (int i = 0; i < 10; i++) begin
            // Even steps are illegal opcodes, odd steps a legal op that must clear the flag.
            if (i == 0)          op = 5'd20;
            else if (i % 2 == 0) op = 5'($urandom_range(12, 31));
            else                 op = 5'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            run_op(op, a, b, lat, bcy);
            model(op, a, b, elo, ehi, edz, eil, elat, ebcy);
            tests_run++;
            if ({done, busy, result_lo, result_hi, div_by_zero, illegal_op} !== {2'b10, elo, ehi, edz, eil}
                || lat != elat) begin
                tests_failed++;
                $display("FAIL illegal op=%0d: got lo=%h hi=%h il=%b lat=%0d, want lo=%h hi=%h il=%b lat=%0d",
                         op, result_lo, result_hi, illegal_op, lat, elo, ehi, eil, elat);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] elo, ehi, glo, ghi; logic edz, eil; int elat, ebcy, ndone, dcyc;
        model(5'd8, -32'sd6, 32'd7, elo, ehi, edz, eil, elat, ebcy);
        @(negedge clock);
        start = 1'b1; opcode = 5'd8; input_a = -32'sd6; input_b = 32'd7;
        ndone = 0; dcyc = 0; glo = '0; ghi = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clock);
            start = (cyc == 5);
            if (cyc == 5) begin opcode = 5'd0; input_a = 32'd2; input_b = 32'd3; end
            if (done) begin ndone++; dcyc = cyc; glo = result_lo; ghi = result_hi; end
        end
        start = 1'b0;
        tests_run++;
        if (ndone != 1 || dcyc != W + 2 || glo !== 32'hFFFFFFD6 || ghi !== 32'hFFFFFFFF
            || glo !== elo || ghi !== ehi) begin
            tests_failed++;
            $display("FAIL ignore_start: got dones=%0d at %0d lo=%h hi=%h, want 1 at %0d lo=%h hi=%h",
                     ndone, dcyc, glo, ghi, W + 2, elo, ehi);
        end
    endtask

    task automatic test_clear();
        int ndone, lat, bcy;
        @(negedge clock);
        start = 1'b1; opcode = 5'd8; input_a = $urandom; input_b = $urandom;
        ndone = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            clear = (cyc == 10);
            if (cyc == 11) begin
                tests_run++;
                if ({busy, done, result_lo, result_hi, div_by_zero, illegal_op} !== '0) begin
                    tests_failed++;
                    $display("FAIL clear_outputs: got busy=%b done=%b lo=%h hi=%h, want all 0",
                             busy, done, result_lo, result_hi);
                end
            end
            if (done) ndone++;
        end
        tests_run++;
        if (ndone != 0) begin
            tests_failed++;
            $display("FAIL clear_no_done: got %0d done pulses, want 0", ndone);
        end
        run_op(5'd0, 32'd2, 32'd3, lat, bcy);
        tests_run++;
        if (!done || result_lo !== 32'd5 || lat != 1) begin
            tests_failed++;
            $display("FAIL clear_then_add: got done=%b lo=%h lat=%0d, want done=1 lo=5 lat=1", done, result_lo, lat);
        end
        @(negedge clock);
        clear = 1'b1; start = 1'b1; opcode = 5'd0; input_a = 32'd7; input_b = 32'd8;
        @(negedge clock);
        clear = 1'b0; start = 1'b0;
        tests_run++;
        if (done !== 1'b0 || result_lo !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_wins: got done=%b lo=%h busy=%b, want 0 0 0", done, result_lo, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, elo, ehi; logic edz, eil; int lat, bcy, elat, ebcy;
        a = $urandom; b = $urandom;
        run_op(5'd8, 32'd1234567, 32'hFFFF0000, lat, bcy);
        // start again in the same cycle that done is high
        start = 1'b1; opcode = 5'd0; input_a = a; input_b = b;
        @(negedge clock);
        start = 1'b0;
        model(5'd0, a, b, elo, ehi, edz, eil, elat, ebcy);
        tests_run++;
        if (done !== 1'b1 || result_lo !== elo || result_hi !== ehi) begin
            tests_failed++;
            $display("FAIL back_to_back: got done=%b lo=%h hi=%h, want done=1 lo=%h hi=%h",
                     done, result_lo, result_hi, elo, ehi);
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (done !== 1'b0 || result_lo !== elo || result_hi !== ehi) begin
            tests_failed++;
            $display("FAIL hold: got done=%b lo=%h hi=%h, want done=0 lo=%h hi=%h",
                     done, result_lo, result_hi, elo, ehi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_illegal();
        test_ignore_start();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
